// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control-step sequencer: state codes,
// opcode values and the opcode class used to pick an execute sequence.
package cpu_ctrl_pkg;

  localparam logic [3:0] StRst   = 4'd0;
  localparam logic [3:0] StT0    = 4'd1;
  localparam logic [3:0] StT1    = 4'd2;
  localparam logic [3:0] StT1w   = 4'd3;
  localparam logic [3:0] StT2    = 4'd4;
  localparam logic [3:0] StT3    = 4'd5;
  localparam logic [3:0] StT4    = 4'd6;
  localparam logic [3:0] StT5    = 4'd7;
  localparam logic [3:0] StT6    = 4'd8;
  localparam logic [3:0] StHalt  = 4'd9;
  localparam logic [3:0] StFault = 4'd10;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpShra = 5'b01010;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [2:0] {
    ClsAlu3,
    ClsUnary,
    ClsMulDiv,
    ClsNop,
    ClsHalt,
    ClsIllegal
  } op_class_e;

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational opcode classifier; the sequencer registers its result at T3.
module ctrl_op_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output op_class_e      op_class
);

  logic [4:0] op5;
  assign op5 = 5'(opcode);

  always_comb begin
    op_class = ClsIllegal;
    case (op5)
      OpAdd, OpSub, OpAnd, OpOr, OpRor,
      OpRol, OpShr, OpShra, OpShl:        op_class = ClsAlu3;
      OpNeg, OpNot:                       op_class = ClsUnary;
      OpMul, OpDiv:                       op_class = ClsMulDiv;
      OpNop:                              op_class = ClsNop;
      OpHalt:                             op_class = ClsHalt;
      default:                            op_class = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/control_unit_seq.sv
// Hardwired control-step sequencer: fetch (T0-T2 with a bounded memory wait),
// then an execute sequence chosen by the opcode class latched at T3.
module control_unit_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned OPW      = 5
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [31:0]    IR,
  input  logic           mem_rdy,
  output logic           PCout,
  output logic           ZHighout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           ZLowIn,
  output logic           ZHighIn,
  output logic           HIin,
  output logic           LOin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           Run,
  output logic           Fault
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d, wait_inc;
  op_class_e       cls_q, cls_live;
  logic [OPW-1:0]  op_q, opcode;

  assign opcode   = IR[31:32-OPW];
  assign wait_inc = wait_q + CntW'(1);

  // Register fields are decoded by the datapath's select-and-encode logic.
  logic unused_ir;
  assign unused_ir = ^IR[31-OPW:0];

  ctrl_op_decode #(
    .OPW (OPW)
  ) u_op_decode (
    .opcode   (opcode),
    .op_class (cls_live)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StRst: state_d = StT0;
      StT0:  state_d = StT1;
      StT1:  state_d = StT1w;
      StT1w: begin
        if (mem_rdy) begin
          state_d = StT2;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == CntW'(WAIT_MAX)) state_d = StFault;
        end
      end
      StT2: begin
        state_d = StT3;
        wait_d  = '0;
      end
      StT3: begin
        case (cls_live)
          ClsAlu3:   state_d = StT4;
          ClsUnary:  state_d = StT5;
          ClsMulDiv: state_d = StT4;
          ClsNop:    state_d = StT0;
          ClsHalt:   state_d = StHalt;
          default:   state_d = StFault;
        endcase
      end
      StT4:    state_d = StT5;
      StT5:    state_d = (cls_q == ClsMulDiv) ? StT6 : StT0;
      StT6:    state_d = StT0;
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= StRst;
      wait_q  <= '0;
      cls_q   <= ClsNop;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      // Later steps use the latched copy so IR may change after T3.
      if (state_q == StT3) begin
        cls_q <= cls_live;
        op_q  <= opcode;
      end
    end
  end

  always_comb begin
    PCout    = 1'b0;
    ZHighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = '0;
    Run      = 1'b1;
    Fault    = 1'b0;
    unique case (state_q)
      StRst, StHalt: Run = 1'b0;
      StFault: begin
        Run   = 1'b0;
        Fault = 1'b1;
      end
      StT0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
        alu_op = OPW'(OpAdd);
      end
      StT1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
      end
      StT1w: begin
        Read  = 1'b1;
        MDRin = mem_rdy;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        case (cls_live)
          ClsAlu3: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          ClsUnary: begin
            Grb    = 1'b1;
            Rout   = 1'b1;
            ZLowIn = 1'b1;
            alu_op = opcode;
          end
          ClsMulDiv: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        Rout   = 1'b1;
        ZLowIn = 1'b1;
        alu_op = op_q;
        if (cls_q == ClsMulDiv) begin
          Grb     = 1'b1;
          ZHighIn = 1'b1;
        end else begin
          Grc = 1'b1;
        end
      end
      StT5: begin
        Zlowout = 1'b1;
        if (cls_q == ClsMulDiv) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      StT6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
      end
      default: Run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_unit_seq.sv
// Self-checking bench for control_unit_seq: directed and random instruction
// streams compared cycle by cycle against an expected strobe trace.
module tb_control_unit_seq;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic [31:0] IR = '0;
  logic        mem_rdy = 1'b0;
  logic PCout, ZHighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn;
  logic ZHighIn, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, Fault;
  logic [4:0] alu_op;

  always #5 Clock = ~Clock;

  control_unit_seq #(
    .WAIT_MAX (15),
    .OPW      (5)
  ) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .IR       (IR),
    .mem_rdy  (mem_rdy),
    .PCout    (PCout),
    .ZHighout (ZHighout),
    .Zlowout  (Zlowout),
    .MDRout   (MDRout),
    .MARin    (MARin),
    .PCin     (PCin),
    .MDRin    (MDRin),
    .IRin     (IRin),
    .Yin      (Yin),
    .ZLowIn   (ZLowIn),
    .ZHighIn  (ZHighIn),
    .HIin     (HIin),
    .LOin     (LOin),
    .IncPC    (IncPC),
    .Read     (Read),
    .Gra      (Gra),
    .Grb      (Grb),
    .Grc      (Grc),
    .Rin      (Rin),
    .Rout     (Rout),
    .alu_op   (alu_op),
    .Run      (Run),
    .Fault    (Fault)
  );

  localparam logic [19:0] M_PCOUT    = 20'd1 << 19;
  localparam logic [19:0] M_ZHIGHOUT = 20'd1 << 18;
  localparam logic [19:0] M_ZLOWOUT  = 20'd1 << 17;
  localparam logic [19:0] M_MDROUT   = 20'd1 << 16;
  localparam logic [19:0] M_MARIN    = 20'd1 << 15;
  localparam logic [19:0] M_PCIN     = 20'd1 << 14;
  localparam logic [19:0] M_MDRIN    = 20'd1 << 13;
  localparam logic [19:0] M_IRIN     = 20'd1 << 12;
  localparam logic [19:0] M_YIN      = 20'd1 << 11;
  localparam logic [19:0] M_ZLOWIN   = 20'd1 << 10;
  localparam logic [19:0] M_ZHIGHIN  = 20'd1 << 9;
  localparam logic [19:0] M_HIIN     = 20'd1 << 8;
  localparam logic [19:0] M_LOIN     = 20'd1 << 7;
  localparam logic [19:0] M_INCPC    = 20'd1 << 6;
  localparam logic [19:0] M_READ     = 20'd1 << 5;
  localparam logic [19:0] M_GRA      = 20'd1 << 4;
  localparam logic [19:0] M_GRB      = 20'd1 << 3;
  localparam logic [19:0] M_GRC      = 20'd1 << 2;
  localparam logic [19:0] M_RIN      = 20'd1 << 1;
  localparam logic [19:0] M_ROUT     = 20'd1 << 0;

  logic [19:0] strobes;
  logic [26:0] obs;
  assign strobes = {PCout, ZHighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn,
                    ZHighIn, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout};
  assign obs = {strobes, alu_op, Run, Fault};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [26:0] ex(input logic [19:0] s, input logic [4:0] alu,
                                     input logic run, input logic flt);
    return {s, alu, run, flt};
  endfunction

  // One clock of stimulus followed by a mid-cycle check of the expected outputs.
  task automatic step(input string tag, input logic [31:0] ir, input logic rdy,
                      input logic [26:0] exp);
    @(posedge Clock);
    #1;
    IR      = ir;
    mem_rdy = rdy;
    @(negedge Clock);
    check_eq(tag, obs, exp);
    check_eq("bus_onehot", {26'd0, $onehot0({PCout, ZHighout, Zlowout, MDRout, Rout})}, 27'd1);
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    Clear = 1'b0;
    @(negedge Clock);
    check_eq("reset_outputs", obs, 27'd0);
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Clear = 1'b1;
    @(negedge Clock);
    check_eq("rst_state", obs, 27'd0);
  endtask

  task automatic fetch(input logic [31:0] instr, input int dly);
    step("T0", $urandom(), 1'($urandom_range(0, 1)),
         ex(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 5'b00011, 1'b1, 1'b0));
    step("T1", $urandom(), 1'($urandom_range(0, 1)), ex(M_ZLOWOUT | M_PCIN, 5'd0, 1'b1, 1'b0));
    for (int i = 0; i < dly; i++) step("T1W_wait", $urandom(), 1'b0, ex(M_READ, 5'd0, 1'b1, 1'b0));
    step("T1W_rdy", $urandom(), 1'b1, ex(M_READ | M_MDRIN, 5'd0, 1'b1, 1'b0));
    step("T2", instr, 1'($urandom_range(0, 1)), ex(M_MDROUT | M_IRIN, 5'd0, 1'b1, 1'b0));
  endtask

  // Expected execute trace from the instruction's class; IR is scrambled after T3.
  task automatic execute(input logic [31:0] instr);
    logic [4:0] opc;
    opc = instr[31:27];
    if (opc inside {[5'd3:5'd11]}) begin
      step("alu3_T3", instr, 1'b0, ex(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, 1'b0));
      step("alu3_T4", $urandom(), 1'b1, ex(M_GRC | M_ROUT | M_ZLOWIN, opc, 1'b1, 1'b0));
      step("alu3_T5", $urandom(), 1'b0, ex(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0));
    end else if (opc inside {5'd17, 5'd18}) begin
      step("unary_T3", instr, 1'b1, ex(M_GRB | M_ROUT | M_ZLOWIN, opc, 1'b1, 1'b0));
      step("unary_T5", $urandom(), 1'b0, ex(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0));
    end else if (opc inside {5'd15, 5'd16}) begin
      step("muldiv_T3", instr, 1'b0, ex(M_GRA | M_ROUT | M_YIN, 5'd0, 1'b1, 1'b0));
      step("muldiv_T4", $urandom(), 1'b1,
           ex(M_GRB | M_ROUT | M_ZLOWIN | M_ZHIGHIN, opc, 1'b1, 1'b0));
      step("muldiv_T5", $urandom(), 1'b0, ex(M_ZLOWOUT | M_LOIN, 5'd0, 1'b1, 1'b0));
      step("muldiv_T6", $urandom(), 1'b1, ex(M_ZHIGHOUT | M_HIIN, 5'd0, 1'b1, 1'b0));
    end else if (opc == 5'd26) begin
      step("nop_T3", instr, 1'b1, ex(20'd0, 5'd0, 1'b1, 1'b0));
    end else if (opc == 5'd27) begin
      step("halt_T3", instr, 1'b1, ex(20'd0, 5'd0, 1'b1, 1'b0));
      for (int i = 0; i < 3; i++) step("halted", $urandom(), 1'($urandom_range(0, 1)), 27'd0);
    end else begin
      step("illegal_T3", instr, 1'b1, ex(20'd0, 5'd0, 1'b1, 1'b0));
      for (int i = 0; i < 3; i++)
        step("fault_hold", $urandom(), 1'($urandom_range(0, 1)), ex(20'd0, 5'd0, 1'b0, 1'b1));
    end
  endtask

  logic [4:0] legal_ops [14] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                 5'd15, 5'd16, 5'd17, 5'd18, 5'd26};

  initial begin
    logic [31:0] instr;
    do_reset();

    // and R1,R2,R3 then mul R4,R2, then a slow memory read.
    fetch(32'h28918000, 0);
    execute(32'h28918000);
    fetch(32'h7A100000, 0);
    execute(32'h7A100000);
    fetch(32'h28918000, 3);
    execute(32'h28918000);

    // Random stream of legal instructions with random memory latency.
    for (int n = 0; n < 30; n++) begin
      instr = {legal_ops[$urandom_range(0, 13)], 27'($urandom())};
      fetch(instr, $urandom_range(0, 6));
      execute(instr);
    end

    // Longest wait that still completes.
    fetch(32'h18000000, 14);
    execute(32'h18000000);

    // halt, then an illegal opcode.
    fetch(32'hD8000000, 1);
    execute(32'hD8000000);
    do_reset();
    fetch(32'hF8123456, 0);
    execute(32'hF8123456);

    // Memory never ready: timeout lands in FAULT.
    do_reset();
    step("T0", $urandom(), 1'b0, ex(M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 5'b00011, 1'b1, 1'b0));
    step("T1", $urandom(), 1'b0, ex(M_ZLOWOUT | M_PCIN, 5'd0, 1'b1, 1'b0));
    for (int i = 0; i < 15; i++) step("T1W_timeout", $urandom(), 1'b0, ex(M_READ, 5'd0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      step("timeout_fault", $urandom(), 1'b1, ex(20'd0, 5'd0, 1'b0, 1'b1));

    // Clear mid-instruction during T4 of an add.
    do_reset();
    fetch(32'h18918000, 0);
    step("abort_T3", 32'h18918000, 1'b0, ex(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, 1'b0));
    step("abort_T4", $urandom(), 1'b0, ex(M_GRC | M_ROUT | M_ZLOWIN, 5'b00011, 1'b1, 1'b0));
    #1;
    Clear = 1'b0;
    #1;
    check_eq("async_clear", obs, 27'd0);
    @(posedge Clock);
    #1;
    Clear = 1'b1;
    @(negedge Clock);
    check_eq("rst_after_abort", obs, 27'd0);
    fetch(32'h18918000, 0);
    execute(32'h18918000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
